// File: rtl/ascii_dec_bin_stream_pkg.sv
// Shared definitions for the serial ASCII-decimal to binary converter:
// ASCII digit bounds and the converter FSM state encoding.
package ascii_dec_bin_stream_pkg;

   localparam logic [6:0] ASCII_ZERO = 7'h30;
   localparam logic [6:0] ASCII_NINE = 7'h39;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII digit classifier: flags '0'..'9' and yields its value.
module ascii_digit_decode
   import ascii_dec_bin_stream_pkg::*;
(
   input  logic [6:0] in_char,
   output logic       is_digit,
   output logic [3:0] digit
);

   // Low nibble of 0x30..0x39 is already the digit value.
   always_comb begin
      is_digit = (in_char >= ASCII_ZERO) && (in_char <= ASCII_NINE);
      digit    = is_digit ? in_char[3:0] : 4'd0;
   end

endmodule

// File: rtl/ascii_dec_bin_stream.sv
// Serial ASCII-decimal to binary converter: accumulates an MSB-first digit
// stream into an unsigned result, flagging non-digits and over-length numbers.
module ascii_dec_bin_stream
   import ascii_dec_bin_stream_pkg::*;
#(
   parameter int NDIG  = 4,
   parameter int OUT_W = $clog2(10**NDIG)
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [6:0]                 in_char,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           out_bin,
   output logic [$clog2(NDIG+1)-1:0]  out_ndig,
   output logic                       out_err
);

   localparam int NW = $clog2(NDIG+1);
   localparam logic [NW-1:0] NDIG_MAX = NW'(NDIG);

   state_t          state, state_next;
   logic [OUT_W-1:0] acc, acc_next, acc_mac;
   logic [NW-1:0]   ndig, ndig_next;
   logic            err, err_next;
   logic            is_digit;
   logic [3:0]      digit;
   logic            accept;

   ascii_digit_decode u_decode (
      .in_char  (in_char),
      .is_digit (is_digit),
      .digit    (digit)
   );

   assign in_ready  = (state != ST_DONE);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && in_ready;

   // acc*10 as shift-add at OUT_W+4 bits; it never overflows within NDIG digits.
   assign acc_mac = OUT_W'(({4'd0, acc} << 3) + ({4'd0, acc} << 1)
                           + {{OUT_W{1'b0}}, digit});

   always_comb begin
      state_next = state;
      acc_next   = acc;
      ndig_next  = ndig;
      err_next   = err;
      case (state)
         ST_IDLE, ST_ACCUM: begin
            if (accept) begin
               if (is_digit && (ndig != NDIG_MAX)) begin
                  acc_next  = acc_mac;
                  ndig_next = ndig + NW'(1);
               end else begin
                  err_next = 1'b1;
               end
               state_next = in_last ? ST_DONE : ST_ACCUM;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next = ST_IDLE;
               acc_next   = '0;
               ndig_next  = '0;
               err_next   = 1'b0;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         acc   <= '0;
         ndig  <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         ndig  <= ndig_next;
         err   <= err_next;
      end
   end

   assign out_bin  = acc;
   assign out_ndig = ndig;
   assign out_err  = err;

endmodule

// File: tb/tb_ascii_dec_bin_stream.sv
// Directed self-checking bench for ascii_dec_bin_stream, exercising an
// NDIG=4 and an NDIG=2 instance fed from a shared input stream.
module tb_ascii_dec_bin_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [6:0]  in_char = 7'h00;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready4, out_valid4, out_err4;
   logic [13:0] out_bin4;
   logic [2:0]  out_ndig4;
   logic        in_ready2, out_valid2, out_err2;
   logic [6:0]  out_bin2;
   logic [1:0]  out_ndig2;

   logic        use4 = 1'b1;
   logic        obs_ready, obs_valid, obs_err;
   logic [13:0] obs_bin;
   logic [2:0]  obs_ndig;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ascii_dec_bin_stream #(.NDIG(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .in_char(in_char), .in_last(in_last), .out_valid(out_valid4),
      .out_ready(out_ready), .out_bin(out_bin4), .out_ndig(out_ndig4),
      .out_err(out_err4)
   );

   ascii_dec_bin_stream #(.NDIG(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_char(in_char), .in_last(in_last), .out_valid(out_valid2),
      .out_ready(out_ready), .out_bin(out_bin2), .out_ndig(out_ndig2),
      .out_err(out_err2)
   );

   assign obs_ready = use4 ? in_ready4  : in_ready2;
   assign obs_valid = use4 ? out_valid4 : out_valid2;
   assign obs_err   = use4 ? out_err4   : out_err2;
   assign obs_bin   = use4 ? out_bin4   : {7'd0, out_bin2};
   assign obs_ndig  = use4 ? out_ndig4  : {1'b0, out_ndig2};

   task automatic do_reset();
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst      = 1'b0;
   endtask

   // Offer one character and wait (bounded) until the selected DUT takes it.
   task automatic send_char(input logic [6:0] ch, input logic last);
      int waited = 0;
      in_valid = 1'b1;
      in_char  = ch;
      in_last  = last;
      while (!obs_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!obs_ready) begin
         checks++; errors++;
         $display("[TB] FAIL send_timeout char=%h in_ready=%b required 1", ch, obs_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_result(input string name, input logic [13:0] bin,
                               input logic [2:0] nd, input logic er);
      checks++;
      if (obs_valid !== 1'b1) begin errors++; $display("[TB] FAIL %s_valid got %b required 1", name, obs_valid); end
      checks++;
      if (obs_bin !== bin) begin errors++; $display("[TB] FAIL %s_bin got %0d required %0d", name, obs_bin, bin); end
      checks++;
      if (obs_ndig !== nd) begin errors++; $display("[TB] FAIL %s_ndig got %0d required %0d", name, obs_ndig, nd); end
      checks++;
      if (obs_err !== er) begin errors++; $display("[TB] FAIL %s_err got %b required %b", name, obs_err, er); end
   endtask

   task automatic test_reset();
      use4 = 1'b1;
      out_ready = 1'b1;
      do_reset();
      checks++;
      if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_hs ready=%b valid=%b required 1/0", obs_ready, obs_valid);
      end
      checks++;
      if (obs_bin !== 14'd0 || obs_ndig !== 3'd0 || obs_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_out bin=%0d ndig=%0d err=%b required 0/0/0", obs_bin, obs_ndig, obs_err);
      end
   endtask

   task automatic test_two_digit();
      use4 = 1'b0;
      out_ready = 1'b1;
      do_reset();
      send_char(7'h39, 1'b0);
      send_char(7'h39, 1'b1);
      check_result("n2_99", 14'd99, 3'd2, 1'b0);
      checks++;
      if (obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL n2_done_ready got %b required 0", obs_ready); end
      @(posedge clk); #1;
      checks++;
      if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_bin !== 14'd0) begin
         errors++;
         $display("[TB] FAIL n2_consumed valid=%b ready=%b bin=%0d required 0/1/0", obs_valid, obs_ready, obs_bin);
      end
   endtask

   task automatic test_four_digit();
      use4 = 1'b1;
      out_ready = 1'b1;
      do_reset();
      send_char(7'h30, 1'b0);
      send_char(7'h34, 1'b0);
      send_char(7'h32, 1'b0);
      send_char(7'h37, 1'b1);
      check_result("n4_0427", 14'd427, 3'd4, 1'b0);
      @(posedge clk); #1;
      send_char(7'h35, 1'b1);
      check_result("n4_5", 14'd5, 3'd1, 1'b0);
      @(posedge clk); #1;
      send_char(7'h39, 1'b0);
      send_char(7'h39, 1'b0);
      send_char(7'h39, 1'b0);
      send_char(7'h39, 1'b1);
      check_result("n4_9999", 14'd9999, 3'd4, 1'b0);
   endtask

   task automatic test_errors();
      use4 = 1'b1;
      out_ready = 1'b1;
      do_reset();
      send_char(7'h31, 1'b0);
      send_char(7'h41, 1'b0);
      send_char(7'h33, 1'b1);
      check_result("err_1A3", 14'd13, 3'd2, 1'b1);
      @(posedge clk); #1;
      send_char(7'h38, 1'b1);
      check_result("err_cleared", 14'd8, 3'd1, 1'b0);
      @(posedge clk); #1;
      send_char(7'h2F, 1'b0);
      send_char(7'h3A, 1'b1);
      check_result("err_bounds", 14'd0, 3'd0, 1'b1);
   endtask

   task automatic test_overlength();
      use4 = 1'b0;
      out_ready = 1'b1;
      do_reset();
      send_char(7'h31, 1'b0);
      send_char(7'h32, 1'b0);
      send_char(7'h33, 1'b1);
      check_result("ovl_123", 14'd12, 3'd2, 1'b1);
   endtask

   task automatic test_backpressure();
      use4 = 1'b1;
      out_ready = 1'b0;
      do_reset();
      send_char(7'h35, 1'b0);
      send_char(7'h37, 1'b1);
      in_valid = 1'b1;
      in_char  = 7'h34;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (obs_valid !== 1'b1 || obs_bin !== 14'd57 || obs_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold cyc=%0d valid=%b bin=%0d ready=%b required 1/57/0", i, obs_valid, obs_bin, obs_ready);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_bin !== 14'd0) begin
         errors++;
         $display("[TB] FAIL bp_release valid=%b ready=%b bin=%0d required 0/1/0", obs_valid, obs_ready, obs_bin);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      check_result("bp_next", 14'd4, 3'd1, 1'b0);
   endtask

   task automatic test_reset_mid();
      use4 = 1'b1;
      out_ready = 1'b1;
      do_reset();
      send_char(7'h33, 1'b0);
      send_char(7'h31, 1'b0);
      do_reset();
      checks++;
      if (obs_bin !== 14'd0 || obs_ndig !== 3'd0 || obs_err !== 1'b0 || obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rstmid_clear bin=%0d ndig=%0d err=%b valid=%b ready=%b required 0/0/0/0/1",
                  obs_bin, obs_ndig, obs_err, obs_valid, obs_ready);
      end
      send_char(7'h37, 1'b1);
      check_result("rstmid_7", 14'd7, 3'd1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_two_digit();
      test_four_digit();
      test_errors();
      test_overlength();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
